// File: rtl/dror_pkg.sv
// Shared constants, state encoding and BRAM command helpers for the point cloud loader.
package dror_pkg;
  localparam int N         = 16;
  localparam int LANES     = 8;
  localparam int WORD_W    = N * LANES;
  localparam int WE_W      = WORD_W / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int HDR_WORDS = 1;

  localparam logic [31:0] START_WORD = 32'd0;
  localparam logic [31:0] SIZE_WORD  = 32'd0;
  localparam logic [31:0] DONE_WORD  = 32'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_HDR_SIZE, S_HDR_START, S_POLL, S_CHK, S_ACK
  } state_t;

  typedef struct packed {
    logic              en;
    logic [WE_W-1:0]   we;
    logic [31:0]       addr;
    logic [WORD_W-1:0] data;
  } bram_cmd_t;

  function automatic bram_cmd_t wr_cmd(input logic [31:0] addr, input logic [WORD_W-1:0] data);
    bram_cmd_t c;
    c.en   = 1'b1;
    c.we   = '1;
    c.addr = addr;
    c.data = data;
    return c;
  endfunction

  function automatic bram_cmd_t rd_cmd(input logic [31:0] addr);
    bram_cmd_t c;
    c      = '0;
    c.en   = 1'b1;
    c.addr = addr;
    return c;
  endfunction
endpackage

// File: rtl/lane_packer.sv
// Packs N-bit x/y/z points into WORD_W-bit words; lanes not yet filled stay zero.
module lane_packer
  import dror_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              flush,
  input  logic [N-1:0]      din_x,
  input  logic [N-1:0]      din_y,
  input  logic [N-1:0]      din_z,
  output logic [WORD_W-1:0] word_x,
  output logic [WORD_W-1:0] word_y,
  output logic [WORD_W-1:0] word_z,
  output logic              full
);
  logic [LANE_BITS-1:0] lane_q;
  logic [WORD_W-1:0]    acc_x, acc_y, acc_z;

  assign full = (lane_q == LANE_BITS'(LANES - 1));

  // word_* already contains the point being pushed, so an emitting beat needs no extra cycle
  always_comb begin
    word_x = acc_x;
    word_y = acc_y;
    word_z = acc_z;
    if (push) begin
      word_x[int'(lane_q)*N +: N] = din_x;
      word_y[int'(lane_q)*N +: N] = din_y;
      word_z[int'(lane_q)*N +: N] = din_z;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_q <= '0;
      acc_x  <= '0;
      acc_y  <= '0;
      acc_z  <= '0;
    end else if (clear || (push && (full || flush))) begin
      lane_q <= '0;
      acc_x  <= '0;
      acc_y  <= '0;
      acc_z  <= '0;
    end else if (push) begin
      lane_q <= lane_q + 1'b1;
      acc_x  <= word_x;
      acc_y  <= word_y;
      acc_z  <= word_z;
    end
  end
endmodule

// File: rtl/point_cloud_loader.sv
// Host-side loader: streams points into the x/y/z BRAMs, writes the header, polls done.
// in_x/in_y/in_z/in_last are taken on a clock edge where in_valid and in_ready are both high.
module point_cloud_loader
  import dror_pkg::*;
#(
  parameter int MAX_POINTS = 65536,
  parameter int TIMEOUT    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_x,
  input  logic [N-1:0]      in_y,
  input  logic [N-1:0]      in_z,
  input  logic              in_last,
  output logic [31:0]       addr_x,
  output logic [31:0]       addr_y,
  output logic [31:0]       addr_z,
  output logic [WORD_W-1:0] write_in_x,
  output logic [WORD_W-1:0] write_in_y,
  output logic [WORD_W-1:0] write_in_z,
  input  logic [WORD_W-1:0] read_out_x,
  input  logic [WORD_W-1:0] read_out_y,
  input  logic [WORD_W-1:0] read_out_z,
  output logic              en_x,
  output logic              en_y,
  output logic              en_z,
  output logic              rst_x,
  output logic              rst_y,
  output logic              rst_z,
  output logic [WE_W-1:0]   we_x,
  output logic [WE_W-1:0]   we_y,
  output logic [WE_W-1:0]   we_z,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [31:0]       point_count,
  output state_t            dbg_state
);
  localparam logic [31:0] MAX_P = 32'(MAX_POINTS);
  localparam logic [31:0] TO_P  = 32'(TIMEOUT);

  state_t            state_q, state_d;
  logic [31:0]       count_q, count_d, wd_q, wd_d;
  logic              ovf_q, ovf_d, to_q, to_d, done_d;
  bram_cmd_t         cx_q, cy_q, cz_q, cx_d, cy_d, cz_d;
  logic              accept, flush, pk_clear, pk_full, wd_hit;
  logic [31:0]       data_addr;
  logic [WORD_W-1:0] word_x, word_y, word_z;
  logic              unused_rd;

  assign unused_rd = ^{read_out_x, read_out_y, read_out_z[WORD_W-1:32]};
  assign accept    = in_valid && in_ready;
  assign data_addr = 32'(HDR_WORDS) + (count_q >> LANE_BITS);
  assign wd_hit    = (TIMEOUT != 0) && (wd_q == TO_P - 32'd1);

  lane_packer u_packer (
    .clock  (clock),
    .reset  (reset),
    .clear  (pk_clear),
    .push   (accept),
    .flush  (flush),
    .din_x  (in_x),
    .din_y  (in_y),
    .din_z  (in_z),
    .word_x (word_x),
    .word_y (word_y),
    .word_z (word_z),
    .full   (pk_full)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    to_d     = to_q;
    wd_d     = wd_q;
    cx_d     = '0;
    cy_d     = '0;
    cz_d     = '0;
    done_d   = 1'b0;
    pk_clear = 1'b0;
    flush    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_CLR;
        count_d  = '0;
        ovf_d    = 1'b0;
        to_d     = 1'b0;
        pk_clear = 1'b1;
      end
      S_CLR: begin
        cx_d    = wr_cmd(START_WORD, '0);
        cz_d    = wr_cmd(DONE_WORD, '0);
        state_d = S_LOAD;
      end
      S_LOAD: if (accept) begin
        count_d = count_q + 32'd1;
        flush   = in_last || (count_d == MAX_P);
        if (pk_full || flush) begin
          cx_d = wr_cmd(data_addr, word_x);
          cy_d = wr_cmd(data_addr, word_y);
          cz_d = wr_cmd(data_addr, word_z);
        end
        if (in_last) begin
          state_d = S_HDR_SIZE;
        end else if (count_d == MAX_P) begin
          ovf_d   = 1'b1;
          state_d = S_HDR_SIZE;
        end
      end
      S_HDR_SIZE: begin
        cy_d    = wr_cmd(SIZE_WORD, WORD_W'(count_q));
        state_d = S_HDR_START;
      end
      S_HDR_START: begin
        cx_d    = wr_cmd(START_WORD, WORD_W'(1));
        wd_d    = '0;
        state_d = S_POLL;
      end
      S_POLL: begin
        wd_d    = wd_q + 32'd1;
        state_d = S_CHK;
        if (wd_hit) begin
          to_d    = 1'b1;
          state_d = S_ACK;
        end
      end
      S_CHK: begin
        wd_d = wd_q + 32'd1;
        if (read_out_z[31:0] != 32'd0) begin
          state_d = S_ACK;
        end else if (wd_hit) begin
          to_d    = 1'b1;
          state_d = S_ACK;
        end else begin
          state_d = S_POLL;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Keyed on the next state so the registered read lands while in POLL and its data in CHK
    if (state_d == S_POLL) cz_d = rd_cmd(DONE_WORD);
    if (state_d == S_ACK) begin
      cx_d   = wr_cmd(START_WORD, '0);
      cz_d   = wr_cmd(DONE_WORD, '0);
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      wd_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      cz_q     <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      to_q     <= to_d;
      wd_q     <= wd_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      cz_q     <= cz_d;
      done     <= done_d;
      busy     <= (state_d != S_IDLE);
      in_ready <= (state_d == S_LOAD) && (count_d < MAX_P);
    end
  end

  assign {en_x, we_x, addr_x, write_in_x} = cx_q;
  assign {en_y, we_y, addr_y, write_in_y} = cy_q;
  assign {en_z, we_z, addr_z, write_in_z} = cz_q;
  assign rst_x       = 1'b0;
  assign rst_y       = 1'b0;
  assign rst_z       = 1'b0;
  assign point_count = count_q;
  assign overflow    = ovf_q;
  assign timeout     = to_q;
  assign dbg_state   = state_q;
endmodule

// File: doc/point_cloud_loader.md
Name: point_cloud_loader

Overview:
Host-side writer that fills the x/y/z point BRAMs consumed by the denoising datapath.
- Accepts a stream of 16-bit x/y/z points and packs 8 points per 128-bit word into three BRAMs.
- Writes the point-count and start-flag header words.
- Polls the done-flag word, then clears the header and reports completion.

Parameters:
N, 16, coordinate width in bits
LANES, 8, points per BRAM word (N*LANES must equal 128)
HDR_WORDS, 1, words reserved at the base of each BRAM for the header; point data starts at word HDR_WORDS
MAX_POINTS, 65536, capacity in points; the stream is truncated beyond this
TIMEOUT, 0, WAIT_DONE watchdog in cycles; 0 disables the watchdog

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  pulse; begin a load (ignored unless IDLE)
in_valid  in  1  point beat valid
in_ready  out  1  point beat accepted when in_valid&in_ready
in_x/in_y/in_z  in  N each  point coordinates
in_last  in  1  final point of the cloud
addr_x/addr_y/addr_z  out  32 each  BRAM word address
write_in_x/y/z  out  128 each  BRAM write data
read_out_x/y/z  in  128 each  BRAM read data (1-cycle latency)
en_x/en_y/en_z  out  1 each  BRAM enable
rst_x/rst_y/rst_z  out  1 each  BRAM reset, tied 0
we_x/we_y/we_z  out  16 each  byte write enables
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at completion
timeout  out  1  sticky until next start; watchdog expired
overflow  out  1  sticky until next start; stream exceeded MAX_POINTS
point_count  out  32  points written in the current/last load

Behaviour:
- Reset (asserted low, async): state IDLE. Every output is 0, including count, pack register and flags. BRAM contents are left as-is. A reset in any state aborts the load.
- Header layout, word 0 bits [31:0]:
  - x: start flag.
  - y: point count.
  - z: done flag, set nonzero by the datapath.
- Point packing: point i goes to word HDR_WORDS + i/LANES, in lane i%LANES at bits [N*lane+N-1 : N*lane].
- All outputs are registered. A BRAM write is issued the cycle after the accepting beat, with we=16'hFFFF and en=1. Unfilled lanes of a partial final word are written as 0.
- States:
  - IDLE: in_ready=0. On start, clear timeout, overflow and point_count, then go to CLR.
  - CLR: one cycle. Write z[0]=0 and x[0]=0 in parallel. Go to LOAD.
  - LOAD: in_ready=1 while point_count<MAX_POINTS. This sustains 1 point/cycle with no bubble on word boundaries.
    - Each accepted beat increments point_count.
    - A word write is issued when lane LANES-1 is filled, or when in_last is accepted.
    - Accepting in_last goes to HDR.
    - Reaching MAX_POINTS without in_last: set overflow, drop in_ready, flush any partial word, go to HDR.
  - HDR: write y[0]={96'b0, point_count} with x idle. Next cycle write x[0]=1. Go to POLL.
  - POLL: issue a read of z[0] (en_z=1, we_z=0). Go to CHK.
  - CHK: sample read_out_z[31:0].
    - Nonzero: go to ACK.
    - Zero: go back to POLL. The poll period is 2 cycles.
    - Watchdog: counts cycles spent in POLL/CHK. On reaching TIMEOUT (when nonzero), set timeout and go to ACK.
  - ACK: write x[0]=0 and z[0]=0. Pulse done. Go to IDLE.
- start outside IDLE is ignored. in_valid outside LOAD is never accepted.
- Simultaneous in_last and a full lane: a single write, then HDR.
- point_count is 32 bits and never wraps, because MAX_POINTS ≤ 2^31.
- Every cycle without an access drives en=0 and we=0.

Decomposition:
- Shared package `dror_pkg`:
  - N, LANES, HDR_WORDS.
  - Header word offsets (START_WORD, SIZE_WORD, DONE_WORD).
  - State enum.
- One natural sub-module, `lane_packer`: shift/insert of N-bit points into a 128-bit word, with lane index, a full flag and zero-fill on flush.
- The FSM and BRAM muxing stay in the top.

Test Plan:
- 8 points (x=i, y=100+i, z=200+i), last on 8th:
  - One write to word 1 of each BRAM; x word = {16'd7,…,16'd0}.
  - y[0]=8, then x[0]=1.
- 3 points, in_valid gapped 1-on/2-off:
  - Word 1 lanes 0–2 hold the data and lanes 3–7 are zero.
  - y[0]=3, point_count=3.
- 9 points back-to-back:
  - in_ready stays high for 9 cycles; words 1 and 2 are written.
  - Word 2 has lane 0 only; y[0]=9.
- BRAM model sets z[0]=5 forty cycles after x[0]=1:
  - done pulses once within 3 cycles.
  - x[0] and z[0] read 0 afterwards; busy falls.
- MAX_POINTS=16, send 20 points:
  - in_ready drops after 16 beats; overflow=1; y[0]=16.
- TIMEOUT=50 and z[0] never set: timeout=1 and done pulses about 50 cycles after POLL is entered. Then assert reset mid-LOAD in a new run: all outputs are 0 the same cycle, and the next start begins with CLR.
